// File: rtl/fft8_pkg.sv
// fft8_pkg: shared types and sizes for the 8-point radix-2 DIT FFT control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fft8_pkg;

   localparam int N_PTS    = 8;
   localparam int N_STAGES = 3;
   localparam int N_BF     = 4;
   localparam int IDX_W    = $clog2(N_PTS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

   // One butterfly command: upper/lower operand buffer indices and twiddle ROM address.
   typedef struct packed {
      logic [IDX_W-1:0] idx_a;
      logic [IDX_W-1:0] idx_b;
      logic [1:0]       tw_addr;
   } bf_cmd_t;

endpackage

// File: rtl/fft8_bf_addr_gen.sv
// fft8_bf_addr_gen: maps (stage, butterfly) to operand indices and twiddle address.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller holds stage/b stable while a command is stalled.
//
// Ports:
//   stage - current FFT stage, 0..2 (3 is clamped to 2)
//   b     - butterfly number within the stage, 0..3
//   cmd   - idx_a, idx_b = idx_a + span, tw_addr = pos << (2 - stage)
module fft8_bf_addr_gen
   import fft8_pkg::*;
(
   input  logic [1:0] stage,
   input  logic [1:0] b,
   output bf_cmd_t    cmd
);

   logic [1:0]       s;
   logic [IDX_W-1:0] b_w;
   logic [IDX_W-1:0] span;
   logic [IDX_W-1:0] pos;
   logic [IDX_W-1:0] grp;
   logic [IDX_W-1:0] tw_w;

   always_comb begin
      // Stage 3 never occurs; clamping keeps the shift amounts in range regardless.
      s    = (stage > 2'd2) ? 2'd2 : stage;
      b_w  = IDX_W'(b);
      span = IDX_W'(1) << s;
      pos  = b_w & (span - IDX_W'(1));
      grp  = b_w >> s;
      tw_w = pos << (2'd2 - s);

      cmd         = '0;
      cmd.idx_a   = (grp << (s + 2'd1)) + pos;
      cmd.idx_b   = cmd.idx_a + span;
      cmd.tw_addr = tw_w[1:0];
   end

endmodule

// File: rtl/fft8_bf_sequencer.sv
// fft8_bf_sequencer: walks 3 stages x 4 butterflies issuing one command per accepted cycle.
// Latency: 12 + 3*BF_LAT + 1 cycles from first valid to o_done when never stalled.
// Backpressure: o_bf_valid/i_bf_ready handshake; command outputs hold while i_bf_ready is low.
//
// Ports:
//   i_clk, i_rst       - rising-edge clock, asynchronous active-high reset
//   i_start            - start request, honoured only in IDLE (never queued)
//   i_bf_ready         - butterfly datapath accepts the command this cycle
//   o_bf_valid         - o_idx_a/o_idx_b/o_tw_addr carry a valid command
//   o_stage            - current stage 0..2
//   o_busy, o_done     - busy outside IDLE; one-cycle done pulse after stage 2 drains
//   o_tw_conj          - conjugate-twiddle flag
// Build option FFT_INVERSE_EN: adds i_inverse, latched with i_start and driven on
// o_tw_conj while busy; without it o_tw_conj is tied 0.
module fft8_bf_sequencer
   import fft8_pkg::*;
#(
   parameter int unsigned BF_LAT = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_bf_ready,
`ifdef FFT_INVERSE_EN
   input  logic       i_inverse,
`endif
   output logic       o_bf_valid,
   output logic [2:0] o_idx_a,
   output logic [2:0] o_idx_b,
   output logic [1:0] o_tw_addr,
   output logic [1:0] o_stage,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_tw_conj
);

   localparam logic [3:0] DRAIN_LOAD = 4'(BF_LAT);
   localparam logic [1:0] LAST_STAGE = 2'(N_STAGES - 1);
   localparam logic [1:0] LAST_BF    = 2'(N_BF - 1);

   seq_state_e state_q, state_d;
   logic [1:0] stage_q, stage_d;
   logic [1:0] b_q, b_d;
   logic [3:0] drain_q, drain_d;
   bf_cmd_t    cmd;

   fft8_bf_addr_gen u_addr_gen (
      .stage (stage_q),
      .b     (b_q),
      .cmd   (cmd)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         stage_q <= 2'd0;
         b_q     <= 2'd0;
         drain_q <= 4'd0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         b_q     <= b_d;
         drain_q <= drain_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      stage_d    = stage_q;
      b_d        = b_q;
      drain_d    = drain_q;
      o_bf_valid = 1'b0;
      o_idx_a    = 3'd0;
      o_idx_b    = 3'd0;
      o_tw_addr  = 2'd0;
      o_stage    = stage_q;
      o_busy     = (state_q != IDLE);
      o_done     = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = ISSUE;
               stage_d = 2'd0;
               b_d     = 2'd0;
            end
         end

         ISSUE: begin
            // Command outputs are gated to zero outside ISSUE so IDLE/reset read all-zero.
            o_bf_valid = 1'b1;
            o_idx_a    = cmd.idx_a;
            o_idx_b    = cmd.idx_b;
            o_tw_addr  = cmd.tw_addr;
            if (i_bf_ready) begin
               if (b_q == LAST_BF) begin
                  b_d = 2'd0;
                  if (DRAIN_LOAD != 4'd0) begin
                     state_d = DRAIN;
                     drain_d = DRAIN_LOAD;
                  end else if (stage_q == LAST_STAGE) begin
                     // Zero-latency datapath: nothing to wait for.
                     state_d = DONE;
                  end else begin
                     stage_d = stage_q + 2'd1;
                  end
               end else begin
                  b_d = b_q + 2'd1;
               end
            end
         end

         DRAIN: begin
            // Wait BF_LAT cycles so the last writeback of this stage lands first.
            drain_d = drain_q - 4'd1;
            if (drain_q <= 4'd1) begin
               drain_d = 4'd0;
               if (stage_q == LAST_STAGE) begin
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
                  stage_d = stage_q + 2'd1;
                  b_d     = 2'd0;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
            stage_d = 2'd0;
            b_d     = 2'd0;
         end

         default: begin
            state_d = IDLE;
            stage_d = 2'd0;
            b_d     = 2'd0;
            drain_d = 4'd0;
         end
      endcase
   end

`ifdef FFT_INVERSE_EN
   logic inv_q;

   // Captured with the start request; re-cleared every idle cycle without a start.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         inv_q <= 1'b0;
      end else if (state_q == IDLE) begin
         inv_q <= i_start & i_inverse;
      end
   end

   assign o_tw_conj = inv_q & (state_q != IDLE);
`else
   assign o_tw_conj = 1'b0;
`endif

endmodule

// File: tb/tb_fft8_bf_sequencer.sv
// tb_fft8_bf_sequencer: directed bench for fft8_bf_sequencer (BF_LAT = 4 and BF_LAT = 0 instances).
// Latency: n/a.
// Backpressure: drives i_bf_ready patterns to exercise command hold.
module tb_fft8_bf_sequencer;

   logic i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Instance with BF_LAT = 4
   logic       rst = 1'b1, start = 1'b0, ready = 1'b1;
   logic       vld, busy, done, conj;
   logic [2:0] idx_a, idx_b;
   logic [1:0] tw, stg;
   // Instance with BF_LAT = 0
   logic       rst0 = 1'b1, start0 = 1'b0, ready0 = 1'b1;
   logic       vld0, busy0, done0, conj0;
   logic [2:0] idx_a0, idx_b0;
   logic [1:0] tw0, stg0;
`ifdef FFT_INVERSE_EN
   logic       inv = 1'b0, inv0 = 1'b0;
`endif

   fft8_bf_sequencer #(.BF_LAT(4)) dut (
      .i_clk      (i_clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_bf_ready (ready),
`ifdef FFT_INVERSE_EN
      .i_inverse  (inv),
`endif
      .o_bf_valid (vld),
      .o_idx_a    (idx_a),
      .o_idx_b    (idx_b),
      .o_tw_addr  (tw),
      .o_stage    (stg),
      .o_busy     (busy),
      .o_done     (done),
      .o_tw_conj  (conj)
   );

   fft8_bf_sequencer #(.BF_LAT(0)) dut0 (
      .i_clk      (i_clk),
      .i_rst      (rst0),
      .i_start    (start0),
      .i_bf_ready (ready0),
`ifdef FFT_INVERSE_EN
      .i_inverse  (inv0),
`endif
      .o_bf_valid (vld0),
      .o_idx_a    (idx_a0),
      .o_idx_b    (idx_b0),
      .o_tw_addr  (tw0),
      .o_stage    (stg0),
      .o_busy     (busy0),
      .o_done     (done0),
      .o_tw_conj  (conj0)
   );

   localparam logic [2:0] EXP_A  [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
   localparam logic [2:0] EXP_B  [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
   localparam logic [1:0] EXP_TW [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
   localparam int EXP_CYC       [12] = '{0, 1, 2, 3, 8, 9, 10, 11, 16, 17, 18, 19};
   localparam int EXP_STALL_CYC [12] = '{0, 3, 4, 7, 12, 15, 16, 19, 24, 27, 28, 31};
   localparam logic READY_PAT [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   int checks = 0;
   int errors = 0;

   // Event recorder for the BF_LAT = 4 instance (records only; tests do the comparing).
   logic [2:0] q_a[$], q_b[$];
   logic [1:0] q_tw[$], q_stg[$];
   int         q_cyc[$], q_done[$];
   int         cyc = 0, n_stall = 0, n_hold_viol = 0, n_busy_drop = 0;
   int         n_busy = 0, n_conj = 0, n_conj_idle = 0;
   logic       p_stalled = 1'b0, p_busy = 1'b0, p_done = 1'b0;
   logic [2:0] p_a = 3'd0, p_b = 3'd0;
   logic [1:0] p_tw = 2'd0, p_stg = 2'd0;

   initial begin
      forever begin
         @(negedge i_clk);
         cyc++;
         if (vld && ready) begin
            q_a.push_back(idx_a);
            q_b.push_back(idx_b);
            q_tw.push_back(tw);
            q_stg.push_back(stg);
            q_cyc.push_back(cyc);
         end
         if (vld && !ready) n_stall++;
         if (p_stalled && (!vld || idx_a != p_a || idx_b != p_b || tw != p_tw || stg != p_stg))
            n_hold_viol++;
         p_stalled = vld && !ready;
         p_a = idx_a; p_b = idx_b; p_tw = tw; p_stg = stg;
         if (done) q_done.push_back(cyc);
         if (p_busy && !busy && !p_done) n_busy_drop++;
         p_busy = busy;
         p_done = done;
         if (busy) n_busy++;
         if (conj) n_conj++;
         if (!busy && conj) n_conj_idle++;
      end
   end

   task automatic next_cycle();
      @(posedge i_clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1; rst0 = 1'b1; start = 1'b0; start0 = 1'b0; ready = 1'b1; ready0 = 1'b1;
      repeat (2) next_cycle();
      #1;
      checks++; if (vld !== 1'b0)   begin errors++; $display("FAIL reset_valid got=%0b exp=0", vld); end
      checks++; if (idx_a !== 3'd0) begin errors++; $display("FAIL reset_idx_a got=%0d exp=0", idx_a); end
      checks++; if (idx_b !== 3'd0) begin errors++; $display("FAIL reset_idx_b got=%0d exp=0", idx_b); end
      checks++; if (tw !== 2'd0)    begin errors++; $display("FAIL reset_tw got=%0d exp=0", tw); end
      checks++; if (stg !== 2'd0)   begin errors++; $display("FAIL reset_stage got=%0d exp=0", stg); end
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
      checks++; if (conj !== 1'b0)  begin errors++; $display("FAIL reset_conj got=%0b exp=0", conj); end
      rst = 1'b0; rst0 = 1'b0;
      repeat (3) next_cycle();
      checks++; if (busy !== 1'b0 || vld !== 1'b0)
         begin errors++; $display("FAIL idle_after_reset busy=%0b valid=%0b exp 0/0", busy, vld); end
      checks++; if (idx_b !== 3'd0) begin errors++; $display("FAIL idle_idx_b got=%0d exp=0", idx_b); end
   endtask

   task automatic test_nominal();
      int n0, d0;
      n0 = q_a.size(); d0 = q_done.size();
      ready = 1'b1; start = 1'b1;
      next_cycle();
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nominal_busy_rise got=%0b exp=1", busy); end
      for (int k = 0; k < 200 && q_done.size() == d0; k++) next_cycle();
      checks++; if (q_done.size() == d0) begin errors++; $display("FAIL nominal_done_timeout got=none exp=pulse"); end
      repeat (3) next_cycle();
      checks++; if (q_a.size() - n0 != 12)
         begin errors++; $display("FAIL nominal_cmd_count got=%0d exp=12", q_a.size() - n0); end
      for (int i = 0; i < 12; i++) begin
         if (n0 + i < q_a.size()) begin
            checks++;
            if (q_a[n0+i] !== EXP_A[i] || q_b[n0+i] !== EXP_B[i] || q_tw[n0+i] !== EXP_TW[i] ||
                q_stg[n0+i] !== 2'(i / 4) || q_cyc[n0+i] - q_cyc[n0] != EXP_CYC[i]) begin
               errors++;
               $display("FAIL nominal_cmd%0d got a=%0d b=%0d tw=%0d s=%0d t=%0d exp a=%0d b=%0d tw=%0d s=%0d t=%0d",
                        i, q_a[n0+i], q_b[n0+i], q_tw[n0+i], q_stg[n0+i], q_cyc[n0+i] - q_cyc[n0],
                        EXP_A[i], EXP_B[i], EXP_TW[i], i / 4, EXP_CYC[i]);
            end
         end
      end
      if (q_done.size() > d0 && q_a.size() > n0) begin
         checks++; if (q_done[d0] - q_cyc[n0] != 24)
            begin errors++; $display("FAIL nominal_done_cycle got=%0d exp=24", q_done[d0] - q_cyc[n0]); end
      end
      checks++; if (q_done.size() - d0 != 1)
         begin errors++; $display("FAIL nominal_done_count got=%0d exp=1", q_done.size() - d0); end
      checks++; if (busy !== 1'b0 || stg !== 2'd0)
         begin errors++; $display("FAIL nominal_idle busy=%0b stage=%0d exp 0/0", busy, stg); end
   endtask

   task automatic test_stall();
      int n0, d0, s0, h0;
      n0 = q_a.size(); d0 = q_done.size(); s0 = n_stall; h0 = n_hold_viol;
      ready = 1'b1; start = 1'b1;
      next_cycle();
      start = 1'b0;
      for (int r = 0; r < 400 && q_done.size() == d0; r++) begin
         ready = READY_PAT[r % 4];
         next_cycle();
      end
      ready = 1'b1;
      checks++; if (q_done.size() == d0) begin errors++; $display("FAIL stall_done_timeout got=none exp=pulse"); end
      repeat (3) next_cycle();
      checks++; if (q_a.size() - n0 != 12)
         begin errors++; $display("FAIL stall_cmd_count got=%0d exp=12", q_a.size() - n0); end
      for (int i = 0; i < 12; i++) begin
         if (n0 + i < q_a.size()) begin
            checks++;
            if (q_a[n0+i] !== EXP_A[i] || q_b[n0+i] !== EXP_B[i] || q_tw[n0+i] !== EXP_TW[i] ||
                q_cyc[n0+i] - q_cyc[n0] != EXP_STALL_CYC[i]) begin
               errors++;
               $display("FAIL stall_cmd%0d got a=%0d b=%0d tw=%0d t=%0d exp a=%0d b=%0d tw=%0d t=%0d",
                        i, q_a[n0+i], q_b[n0+i], q_tw[n0+i], q_cyc[n0+i] - q_cyc[n0],
                        EXP_A[i], EXP_B[i], EXP_TW[i], EXP_STALL_CYC[i]);
            end
         end
      end
      checks++; if (n_stall - s0 != 12)
         begin errors++; $display("FAIL stall_cycles got=%0d exp=12", n_stall - s0); end
      checks++; if (n_hold_viol - h0 != 0)
         begin errors++; $display("FAIL stall_hold got=%0d changes exp=0", n_hold_viol - h0); end
      if (q_done.size() > d0 && q_a.size() > n0) begin
         checks++; if (q_done[d0] - q_cyc[n0] != 36)
            begin errors++; $display("FAIL stall_done_cycle got=%0d exp=36", q_done[d0] - q_cyc[n0]); end
      end
   endtask

   task automatic test_start_ignored();
      int n0, d0, bd0;
      n0 = q_a.size(); d0 = q_done.size(); bd0 = n_busy_drop;
      ready = 1'b1; start = 1'b1;
      next_cycle();
      start = 1'b0;
      for (int k = 0; k < 100 && q_a.size() < n0 + 5; k++) next_cycle();
      checks++; if (stg !== 2'd1) begin errors++; $display("FAIL ignored_in_stage1 got=%0d exp=1", stg); end
      start = 1'b1;
      next_cycle();
      start = 1'b0;
      for (int k = 0; k < 200 && q_done.size() == d0; k++) next_cycle();
      repeat (40) next_cycle();
      checks++; if (q_done.size() - d0 != 1)
         begin errors++; $display("FAIL ignored_done_count got=%0d exp=1", q_done.size() - d0); end
      checks++; if (q_a.size() - n0 != 12)
         begin errors++; $display("FAIL ignored_cmd_count got=%0d exp=12", q_a.size() - n0); end
      checks++; if (n_busy_drop - bd0 != 0)
         begin errors++; $display("FAIL ignored_busy_drop got=%0d exp=0", n_busy_drop - bd0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_idle_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      int n0, d0;
      n0 = q_a.size(); d0 = q_done.size();
      ready = 1'b1; start = 1'b1;
      for (int k = 0; k < 200 && q_a.size() < n0 + 13; k++) next_cycle();
      start = 1'b0;
      for (int k = 0; k < 200 && q_done.size() < d0 + 2; k++) next_cycle();
      repeat (3) next_cycle();
      checks++; if (q_a.size() - n0 != 24)
         begin errors++; $display("FAIL b2b_cmd_count got=%0d exp=24", q_a.size() - n0); end
      if (q_a.size() >= n0 + 13 && q_done.size() >= d0 + 2) begin
         checks++; if (q_cyc[n0+12] - q_done[d0] != 2)
            begin errors++; $display("FAIL b2b_restart_gap got=%0d exp=2", q_cyc[n0+12] - q_done[d0]); end
         checks++; if (q_done[d0+1] - q_cyc[n0+12] != 24)
            begin errors++; $display("FAIL b2b_second_done got=%0d exp=24", q_done[d0+1] - q_cyc[n0+12]); end
         checks++; if (q_a[n0+12] !== 3'd0 || q_b[n0+12] !== 3'd1 || q_stg[n0+12] !== 2'd0)
            begin errors++; $display("FAIL b2b_second_first got a=%0d b=%0d s=%0d exp 0/1/0",
                                     q_a[n0+12], q_b[n0+12], q_stg[n0+12]); end
      end else begin
         checks++; errors++;
         $display("FAIL b2b_timeout got cmds=%0d dones=%0d exp 24/2", q_a.size() - n0, q_done.size() - d0);
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_rst_mid();
      int n0, d0;
      n0 = q_a.size();
      ready = 1'b1; start = 1'b1;
      next_cycle();
      start = 1'b0;
      for (int k = 0; k < 200 && q_a.size() < n0 + 12; k++) next_cycle();
      next_cycle();
      checks++; if (busy !== 1'b1 || stg !== 2'd2 || vld !== 1'b0)
         begin errors++; $display("FAIL rst_pre_drain busy=%0b stage=%0d valid=%0b exp 1/2/0", busy, stg, vld); end
      #1 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || stg !== 2'd0 || vld !== 1'b0 || done !== 1'b0)
         begin errors++; $display("FAIL rst_async busy=%0b stage=%0d valid=%0b done=%0b exp 0/0/0/0",
                                  busy, stg, vld, done); end
      d0 = q_done.size();
      repeat (2) next_cycle();
      rst = 1'b0;
      repeat (40) next_cycle();
      checks++; if (q_done.size() != d0)
         begin errors++; $display("FAIL rst_no_done got=%0d exp=0", q_done.size() - d0); end
      test_nominal();
   endtask

   task automatic test_lat0();
      ready0 = 1'b1; start0 = 1'b1;
      next_cycle();
      start0 = 1'b0;
      for (int k = 0; k < 12; k++) begin
         checks++;
         if (vld0 !== 1'b1 || idx_a0 !== EXP_A[k] || idx_b0 !== EXP_B[k] || tw0 !== EXP_TW[k] || stg0 !== 2'(k / 4)) begin
            errors++;
            $display("FAIL lat0_cmd%0d got v=%0b a=%0d b=%0d tw=%0d s=%0d exp v=1 a=%0d b=%0d tw=%0d s=%0d",
                     k, vld0, idx_a0, idx_b0, tw0, stg0, EXP_A[k], EXP_B[k], EXP_TW[k], k / 4);
         end
         next_cycle();
      end
      checks++; if (done0 !== 1'b1 || vld0 !== 1'b0 || busy0 !== 1'b1)
         begin errors++; $display("FAIL lat0_done done=%0b valid=%0b busy=%0b exp 1/0/1", done0, vld0, busy0); end
      next_cycle();
      checks++; if (done0 !== 1'b0 || busy0 !== 1'b0)
         begin errors++; $display("FAIL lat0_idle done=%0b busy=%0b exp 0/0", done0, busy0); end
   endtask

   task automatic test_tw_conj();
      int d0, b0, c0, ci0;
      d0 = q_done.size(); b0 = n_busy; c0 = n_conj; ci0 = n_conj_idle;
      ready = 1'b1; start = 1'b1;
`ifdef FFT_INVERSE_EN
      inv = 1'b1;
`endif
      next_cycle();
      start = 1'b0;
`ifdef FFT_INVERSE_EN
      inv = 1'b0;
`endif
      for (int k = 0; k < 200 && q_done.size() == d0; k++) next_cycle();
      repeat (3) next_cycle();
      checks++; if (n_busy - b0 != 25)
         begin errors++; $display("FAIL conj_busy_cycles got=%0d exp=25", n_busy - b0); end
`ifdef FFT_INVERSE_EN
      checks++; if (n_conj - c0 != 25)
         begin errors++; $display("FAIL conj_high_cycles got=%0d exp=25", n_conj - c0); end
`else
      checks++; if (n_conj - c0 != 0)
         begin errors++; $display("FAIL conj_high_cycles got=%0d exp=0", n_conj - c0); end
`endif
      checks++; if (n_conj_idle - ci0 != 0)
         begin errors++; $display("FAIL conj_idle_cycles got=%0d exp=0", n_conj_idle - ci0); end
      checks++; if (conj !== 1'b0) begin errors++; $display("FAIL conj_after_idle got=%0b exp=0", conj); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_nominal();
      test_stall();
      test_start_ignored();
      test_back_to_back();
      test_rst_mid();
      test_lat0();
      test_tw_conj();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft8_bf_sequencer.md
Name: fft8_bf_sequencer

Overview:
- Control sequencer for the 8-point float32 radix-2 DIT FFT core.
- On start, walks 3 stages × 4 butterflies and issues one butterfly command per accepted cycle: operand buffer indices A/B plus the 2-bit twiddle address driven into the twiddle ROM's i_addr.
- Inserts a drain gap between stages so the pipelined butterfly's writebacks land before the next stage reads them.
- Signals done when the last stage has drained.

Parameters:
- BF_LAT, 4, butterfly datapath latency in cycles, from issue accept to writeback. Legal range 0..15.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  start request; honoured only in IDLE.
- i_bf_ready  in  1  butterfly datapath can accept a command this cycle.
- o_bf_valid  out  1  command on o_idx_a/o_idx_b/o_tw_addr is valid.
- o_idx_a  out  3  buffer index of the upper operand.
- o_idx_b  out  3  buffer index of the lower operand.
- o_tw_addr  out  2  twiddle ROM address W^k, k = 0..3.
- o_stage  out  2  current stage, 0..2.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse after stage 2 drains.
- o_tw_conj  out  1  conjugate-twiddle flag; see Optional Feature.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All outputs 0; stage, butterfly and drain counters cleared.
  - Reset mid-operation abandons the transform; no done pulse.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - i_start = 1 → ISSUE, stage = 0, b = 0.
  - o_busy rises the cycle after i_start is sampled.
- ISSUE:
  - o_bf_valid = 1.
  - Command accepted when o_bf_valid & i_bf_ready; then b increments.
  - If i_bf_ready = 0, all command outputs hold stable.
  - Accept at b = 3 → DRAIN with drain counter loaded to BF_LAT. If BF_LAT = 0, skip DRAIN: go to next stage's ISSUE, or to DONE after stage 2.
- Index arithmetic, with stage s, span = 1<<s, pos = b & (span-1), grp = b >> s:
  - idx_a = grp·2·span + pos.
  - idx_b = idx_a + span.
  - tw_addr = pos << (2 - s).
  - Expected sequence: stage 0 tw = 0,0,0,0; stage 1 tw = 0,2,0,2; stage 2 tw = 0,1,2,3.
- DRAIN:
  - o_bf_valid = 0; counter decrements each cycle.
  - At count 1 → stage + 1 with b = 0, back to ISSUE; if stage was 2 → DONE.
- DONE:
  - o_done = 1 for exactly one cycle, o_busy still 1.
  - Next cycle → IDLE; o_stage returns to 0.
- i_start while busy: ignored, never queued.
- i_start held high continuously: a new transform begins in the cycle after returning to IDLE.
- Stall-free throughput: 12 + 3·BF_LAT + 1 cycles from the first valid to o_done (BF_LAT = 4 → 25).
- o_tw_conj: 0 in all states unless the optional feature is compiled in.

Optional Feature:
- FFT_INVERSE_EN defined:
  - Adds input port i_inverse (1 bit), sampled with i_start and latched for the whole transform.
  - o_tw_conj = latched value while o_busy; downstream negates the ROM's o_wi to form W^-k (IFFT).
  - Cleared on reset and in IDLE.
- Undefined: i_inverse port absent; o_tw_conj tied 0.

Decomposition:
- Package fft8_pkg:
  - localparams N_PTS = 8, N_STAGES = 3, N_BF = 4.
  - typedef seq_state_e {IDLE, ISSUE, DRAIN, DONE}.
  - typedef bf_cmd_t {idx_a[2:0], idx_b[2:0], tw_addr[1:0]}.
- One natural sub-module, fft8_bf_addr_gen: pure combinational (stage, b) → bf_cmd_t. Unit-testable against the table above.

Test Plan:
- Reset, then i_start pulse with i_bf_ready = 1, BF_LAT = 4 → exactly 12 valid cycles with (a, b, tw) in order:
  - stage 0: (0,1,0)(2,3,0)(4,5,0)(6,7,0)
  - stage 1: (0,2,0)(1,3,2)(4,6,0)(5,7,2)
  - stage 2: (0,4,0)(1,5,1)(2,6,2)(3,7,3)
  - 4-cycle gaps between stages; o_done at cycle 25 after the first valid.
- i_bf_ready toggled 1,0,0,1 repeatedly → outputs hold stable while ready = 0; same 12-command sequence; o_done delayed by the number of stall cycles.
- i_start pulsed during stage 1 → ignored; exactly one o_done; o_busy never drops mid-run.
- i_rst asserted during stage 2 DRAIN → outputs 0 immediately (async); no o_done; a fresh i_start gives the full 12-command sequence from stage 0.
- BF_LAT = 0 build → 12 consecutive valid cycles with no gaps; o_done on the 13th cycle.
- FFT_INVERSE_EN build, i_inverse = 1 at start then deasserted → o_tw_conj = 1 for the whole run; 0 after return to IDLE.
